// File: rtl/processor_top.sv
// Single-cycle 32-bit MIPS core: fetch, decode, execute, memory access and
// write-back all complete in one CLK period. PC, instruction and ALU result are exported.

module instruction_memory #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  load_en_i,
  input  logic [5:0]            load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic [5:0]            addr_i,
  output logic [DATA_WIDTH-1:0] instr_o
);
  logic [DATA_WIDTH-1:0] Instruction_Memory [0:63];

  // Program image is normally preloaded; the load port is an optional back door.
  always_ff @(posedge clk_i) begin
    if (load_en_i) Instruction_Memory[load_addr_i] <= load_data_i;
  end

  assign instr_o = Instruction_Memory[addr_i];
endmodule

module control_unit (
  input  logic [5:0] opcode_i,
  output logic       RegDst,
  output logic       Jump,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic [1:0] ALUOp
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  always_comb begin
    RegDst   = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = 2'b00;
    case (opcode_i)
      OP_RTYPE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      OP_LW: begin
        ALUSrc   = 1'b1;
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      OP_SW: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_BEQ: begin
        Branch = 1'b1;
        ALUOp  = 2'b01;
      end
      OP_ADDI: begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
      end
      OP_J:    Jump = 1'b1;
      default: ; // unknown opcodes execute as a NOP
    endcase
  end
endmodule

module alu_control (
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ALU_Operation
);
  always_comb begin
    ALU_Operation = 4'b0010;
    case (alu_op_i)
      2'b00: ALU_Operation = 4'b0010;
      2'b01: ALU_Operation = 4'b0110;
      2'b10: begin
        case (funct_i)
          6'b100000: ALU_Operation = 4'b0010;
          6'b100010: ALU_Operation = 4'b0110;
          6'b100100: ALU_Operation = 4'b0000;
          6'b100101: ALU_Operation = 4'b0001;
          6'b101010: ALU_Operation = 4'b0111;
          6'b100111: ALU_Operation = 4'b1100;
          default:   ALU_Operation = 4'b0010;
        endcase
      end
      default: ALU_Operation = 4'b0010;
    endcase
  end
endmodule

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] reg_file_q [0:NUM_REGS-1];

  // $0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) reg_file_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      reg_file_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = reg_file_q[raddr_a_i];
  assign rdata_b_o = reg_file_q[raddr_b_i];
endmodule

module sign_extend #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [15:0]           imm_i,
  output logic [DATA_WIDTH-1:0] ext_o
);
  assign ext_o = {{(DATA_WIDTH-16){imm_i[15]}}, imm_i};
endmodule

module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);
  always_comb begin
    result_o = '0;
    case (op_i)
      4'b0000: result_o = a_i & b_i;
      4'b0001: result_o = a_i | b_i;
      4'b0010: result_o = a_i + b_i;
      4'b0110: result_o = a_i - b_i;
      4'b0111: result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      4'b1100: result_o = ~(a_i | b_i);
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

module data_memory #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [5:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [0:63];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

module processor_top #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic [DATA_WIDTH-1:0] Instruction
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc4, branch_target, jump_target;
  logic [DATA_WIDTH-1:0] instr;
  logic                  reg_dst, jump, branch, mem_read, mem_write;
  logic                  alu_src, reg_write, mem_to_reg;
  logic [1:0]            alu_op;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] rs_data, rt_data, imm_ext, alu_b, alu_result;
  logic [DATA_WIDTH-1:0] mem_rdata, wb_data;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  alu_zero;

  instruction_memory #(.DATA_WIDTH(DATA_WIDTH)) U0_Inst (
    .clk_i      (CLK),
    .load_en_i  (1'b0),
    .load_addr_i(6'd0),
    .load_data_i('0),
    .addr_i     (pc_q[7:2]),
    .instr_o    (instr)
  );

  control_unit U0_Control (
    .opcode_i(instr[31:26]),
    .RegDst  (reg_dst),
    .Jump    (jump),
    .Branch  (branch),
    .MemRead (mem_read),
    .MemWrite(mem_write),
    .ALUSrc  (alu_src),
    .RegWrite(reg_write),
    .MemtoReg(mem_to_reg),
    .ALUOp   (alu_op)
  );

  alu_control U0_ALU_Control (
    .alu_op_i     (alu_op),
    .funct_i      (instr[5:0]),
    .ALU_Operation(alu_operation)
  );

  assign wb_addr = reg_dst ? instr[15:11] : instr[20:16];
  assign wb_data = mem_to_reg ? mem_rdata : alu_result;

  register_file #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) U0_RegFile (
    .clk_i    (CLK),
    .rst_i    (RST),
    .we_i     (reg_write),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr_a_i(instr[25:21]),
    .raddr_b_i(instr[20:16]),
    .rdata_a_o(rs_data),
    .rdata_b_o(rt_data)
  );

  sign_extend #(.DATA_WIDTH(DATA_WIDTH)) U0_Sign_Extend (
    .imm_i(instr[15:0]),
    .ext_o(imm_ext)
  );

  assign alu_b = alu_src ? imm_ext : rt_data;

  alu #(.DATA_WIDTH(DATA_WIDTH)) U0_ALU (
    .op_i    (alu_operation),
    .a_i     (rs_data),
    .b_i     (alu_b),
    .result_o(alu_result),
    .zero_o  (alu_zero)
  );

  data_memory #(.DATA_WIDTH(DATA_WIDTH)) U0_Data_Memory (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (mem_write),
    .addr_i (alu_result[7:2]),
    .wdata_i(rt_data),
    .rdata_o(mem_rdata)
  );

  // Jump outranks a taken branch; everything else falls through to PC+4.
  assign pc4           = pc_q + 32'd4;
  assign branch_target = pc4 + {imm_ext[DATA_WIDTH-3:0], 2'b00};
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pc_d = pc4;
    if (jump)                    pc_d = jump_target;
    else if (branch && alu_zero) pc_d = branch_target;
  end

  always_ff @(posedge CLK) begin
    if (RST) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign PC          = pc_q;
  assign Instruction = instr;
  assign ALU_OUT     = alu_result;
endmodule

// File: tb/tb_processor_top.sv
// Directed bench for processor_top: small hand-assembled programs, expected
// values worked out by hand from the instruction encodings.

module tb_processor_top;
  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] ALU_OUT;
  logic [31:0] Instruction;

  int checks = 0;
  int errors = 0;

  processor_top dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .ALU_OUT    (ALU_OUT),
    .Instruction(Instruction)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {22'd0, dut.U0_Control.RegDst, dut.U0_Control.Jump, dut.U0_Control.Branch,
            dut.U0_Control.MemRead, dut.U0_Control.MemWrite, dut.U0_Control.ALUSrc,
            dut.U0_Control.RegWrite, dut.U0_Control.MemtoReg, dut.U0_Control.ALUOp};
  endfunction

  initial begin
    RST = 1'b1;
    for (int i = 0; i < 64; i++) dut.U0_Inst.Instruction_Memory[i] = 32'h0;
    dut.U0_Inst.Instruction_Memory[0] = 32'h20010005; // addi $1,$0,5
    dut.U0_Inst.Instruction_Memory[1] = 32'h20020003; // addi $2,$0,3
    dut.U0_Inst.Instruction_Memory[2] = 32'h00221820; // add  $3,$1,$2
    dut.U0_Inst.Instruction_Memory[3] = 32'h00222022; // sub  $4,$1,$2
    dut.U0_Inst.Instruction_Memory[4] = 32'h0041282A; // slt  $5,$2,$1
    dut.U0_Inst.Instruction_Memory[5] = 32'h10210002; // beq  $1,$1,+2
    dut.U0_Inst.Instruction_Memory[8] = 32'hFC000000; // undefined opcode
    dut.U0_Inst.Instruction_Memory[9] = 32'h08000000; // j 0

    step();
    check("reset_pc", PC, 32'h0);
    check("reset_instr", Instruction, 32'h20010005);
    for (int r = 0; r < 32; r++) check($sformatf("reset_reg%0d", r), dut.U0_RegFile.reg_file_q[r], 32'h0);
    check("reset_dmem1", dut.U0_Data_Memory.mem_q[1], 32'h0);
    RST = 1'b0;
    #1;
    check("addi1_alu", ALU_OUT, 32'd5);
    check("addi1_regdst", {31'd0, dut.U0_Control.RegDst}, 32'd0);
    check("addi1_alusrc", {31'd0, dut.U0_Control.ALUSrc}, 32'd1);

    step();
    check("pc_4", PC, 32'h4);
    check("reg1_5", dut.U0_RegFile.reg_file_q[1], 32'd5);
    check("addi2_alu", ALU_OUT, 32'd3);

    step();
    check("pc_8", PC, 32'h8);
    check("reg2_3", dut.U0_RegFile.reg_file_q[2], 32'd3);
    check("add_alu", ALU_OUT, 32'd8);
    check("add_regdst", {31'd0, dut.U0_Control.RegDst}, 32'd1);
    check("add_aluop_ctl", {28'd0, dut.U0_ALU_Control.ALU_Operation}, 32'b0010);

    step();
    check("pc_c", PC, 32'hC);
    check("sub_alu", ALU_OUT, 32'd2);
    check("sub_aluop_ctl", {28'd0, dut.U0_ALU_Control.ALU_Operation}, 32'b0110);

    step();
    check("pc_10", PC, 32'h10);
    check("reg3_8", dut.U0_RegFile.reg_file_q[3], 32'd8);
    check("slt_alu", ALU_OUT, 32'd1);
    check("slt_aluop_ctl", {28'd0, dut.U0_ALU_Control.ALU_Operation}, 32'b0111);

    step();
    check("pc_14", PC, 32'h14);
    check("reg5_1", dut.U0_RegFile.reg_file_q[5], 32'd1);
    check("beq_branch", {31'd0, dut.U0_Control.Branch}, 32'd1);
    check("beq_alu", ALU_OUT, 32'd0);

    step();
    check("beq_target", PC, 32'h20);
    check("nop_controls", ctrl_vec(), 32'h0);

    step();
    check("nop_pc4", PC, 32'h24);
    check("j_jump", {31'd0, dut.U0_Control.Jump}, 32'd1);

    step();
    check("j_target", PC, 32'h0);

    step();
    step();
    step();
    check("rerun_pc_c", PC, 32'hC);
    RST = 1'b1;
    step();
    check("midrst_pc", PC, 32'h0);
    for (int r = 1; r <= 5; r++) check($sformatf("midrst_reg%0d", r), dut.U0_RegFile.reg_file_q[r], 32'h0);

    dut.U0_Inst.Instruction_Memory[3] = 32'hAC030004; // sw $3,4($0)
    dut.U0_Inst.Instruction_Memory[4] = 32'h8C060004; // lw $6,4($0)
    dut.U0_Inst.Instruction_Memory[5] = 32'h20000007; // addi $0,$0,7
    RST = 1'b0;
    #1;
    check("p2_addi_alu", ALU_OUT, 32'd5);

    step();
    step();
    step();
    check("sw_pc", PC, 32'hC);
    check("sw_alu", ALU_OUT, 32'd4);
    check("sw_memwrite", {31'd0, dut.U0_Control.MemWrite}, 32'd1);
    check("sw_regwrite", {31'd0, dut.U0_Control.RegWrite}, 32'd0);

    step();
    check("dmem1_8", dut.U0_Data_Memory.mem_q[1], 32'd8);
    check("lw_memread", {31'd0, dut.U0_Control.MemRead}, 32'd1);
    check("lw_alu", ALU_OUT, 32'd4);

    step();
    check("reg6_8", dut.U0_RegFile.reg_file_q[6], 32'd8);
    check("addi_r0_alu", ALU_OUT, 32'd7);

    step();
    check("reg0_zero", dut.U0_RegFile.reg_file_q[0], 32'h0);
    check("pc_18", PC, 32'h18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
